// File: rtl/add_round_key_stage_if.sv
// Block-level bus of the AddRoundKey stage: key/state in from the round controller,
// keyed state with round tag out towards SubBytes.
interface add_round_key_stage_if;
    logic         start_i;
    logic [127:0] key_i;
    logic         valid_i;
    logic [127:0] state_i;
    logic         valid_o;
    logic [127:0] state_o;
    logic [3:0]   round_o;
    logic         last_o;

    modport master (
        output start_i, key_i, valid_i, state_i,
        input  valid_o, state_o, round_o, last_o
    );

    modport slave (
        input  start_i, key_i, valid_i, state_i,
        output valid_o, state_o, round_o, last_o
    );
endinterface

// File: rtl/add_round_key_stage.sv
// Registered AES-128 AddRoundKey stage with an on-the-fly key schedule that
// advances one round key per accepted block and rewinds to the cipher key after round NR.
module s_box (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    // Entry 0 sits in the most significant byte, so the table is indexed by ~a_i.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y_o = SBOX[~a_i];
endmodule

module add_round_key_stage #(
    parameter int NR = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    add_round_key_stage_if.slave         ark
);
    logic [127:0] ckey_q, ckey_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         valid_q, valid_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_q, round_d;

    logic [127:0] cur_key, nxt_key;
    logic [3:0]   cur_rnd;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;

    // rcon for the key that follows round r
    function automatic logic [7:0] rcon_next(input logic [3:0] r);
        case (r)
            4'd0:    rcon_next = 8'h01;
            4'd1:    rcon_next = 8'h02;
            4'd2:    rcon_next = 8'h04;
            4'd3:    rcon_next = 8'h08;
            4'd4:    rcon_next = 8'h10;
            4'd5:    rcon_next = 8'h20;
            4'd6:    rcon_next = 8'h40;
            4'd7:    rcon_next = 8'h80;
            4'd8:    rcon_next = 8'h1b;
            4'd9:    rcon_next = 8'h36;
            default: rcon_next = 8'h00;
        endcase
    endfunction

    // A start in the same cycle as a block keys that block with key_i at round 0.
    assign cur_key = ark.start_i ? ark.key_i : rkey_q;
    assign cur_rnd = ark.start_i ? 4'd0 : rnd_q;

    assign rot_w = {cur_key[23:0], cur_key[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        s_box u_sbox (
            .a_i (rot_w[8*g +: 8]),
            .y_o (sub_w[8*g +: 8])
        );
    end

    assign t_w     = sub_w ^ {rcon_next(cur_rnd), 24'h0};
    assign w0_n    = cur_key[127:96] ^ t_w;
    assign w1_n    = cur_key[95:64]  ^ w0_n;
    assign w2_n    = cur_key[63:32]  ^ w1_n;
    assign w3_n    = cur_key[31:0]   ^ w2_n;
    assign nxt_key = {w0_n, w1_n, w2_n, w3_n};

    always_comb begin
        ckey_d  = ckey_q;
        rkey_d  = rkey_q;
        rnd_d   = rnd_q;
        valid_d = 1'b0;
        state_d = state_q;
        round_d = round_q;
        if (ark.start_i) begin
            ckey_d = ark.key_i;
            rkey_d = ark.key_i;
            rnd_d  = 4'd0;
        end
        if (ark.valid_i) begin
            valid_d = 1'b1;
            state_d = ark.state_i ^ cur_key;
            round_d = cur_rnd;
            if (cur_rnd == 4'(NR)) begin
                rnd_d  = 4'd0;
                rkey_d = ckey_q;
            end else begin
                rnd_d  = cur_rnd + 4'd1;
                rkey_d = nxt_key;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ckey_q  <= '0;
            rkey_q  <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
            state_q <= '0;
            round_q <= '0;
        end else if (en) begin
            ckey_q  <= ckey_d;
            rkey_q  <= rkey_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    assign ark.valid_o = valid_q;
    assign ark.state_o = state_q;
    assign ark.round_o = round_q;
    assign ark.last_o  = valid_q & (round_q == 4'(NR));
endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed bench for add_round_key_stage: cycle table with hand-derived outputs,
// plus hand-written reset sequences.
module tb_add_round_key_stage;
    logic clk = 1'b0;
    logic rst_n;
    logic en;
    always #5 clk = ~clk;

    add_round_key_stage_if bus ();

    add_round_key_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .ark   (bus.slave)
    );

    typedef struct {
        logic         en;
        logic         start;
        logic         valid;
        logic [127:0] key;
        logic [127:0] state;
        logic         ev;
        logic [127:0] es;
        logic [3:0]   er;
        logic         el;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT0   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] ZK1   = 128'h62636363626363636263636362636363;

    logic [127:0] rk [0:10];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [127:0] es,
                           input logic [3:0] er, input logic el);
        chk({tag, " valid_o"}, 128'(bus.valid_o), 128'(ev));
        chk({tag, " state_o"}, bus.state_o, es);
        chk({tag, " round_o"}, 128'(bus.round_o), 128'(er));
        chk({tag, " last_o"},  128'(bus.last_o), 128'(el));
    endtask

    function automatic void add(input logic e, input logic s, input logic v,
                                input logic [127:0] k, input logic [127:0] st,
                                input logic ev, input logic [127:0] es,
                                input logic [3:0] er, input logic el);
        vec_t x;
        x.en = e; x.start = s; x.valid = v; x.key = k; x.state = st;
        x.ev = ev; x.es = es; x.er = er; x.el = el;
        vq.push_back(x);
    endfunction

    task automatic drive(input logic e, input logic s, input logic v,
                         input logic [127:0] k, input logic [127:0] st);
        en = e; bus.start_i = s; bus.valid_i = v; bus.key_i = k; bus.state_i = st;
    endtask

    initial begin
        rk[0]  = K;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Cycle table: inputs for one edge, outputs expected after that edge.
        add(1, 1, 1, K,  PT, 1, CT0, 0, 0);
        add(1, 1, 0, K,  '0, 0, CT0, 0, 0);
        for (int i = 0; i <= 10; i++) begin
            add(1, 0, 1, K2, '0, 1, rk[i], 4'(i), (i == 10));
            if (i == 2 || i == 5)
                add(1, 0, 0, '0, '1, 0, rk[i], 4'(i), 0);
            if (i == 3)
                add(0, 1, 1, K2, '1, 1, rk[3], 4'd3, 0);
            if (i == 7)
                add(0, 0, 1, '0, PT, 1, rk[7], 4'd7, 0);
            if (i == 10) begin
                add(0, 0, 0, '0, '0, 1, rk[10], 4'd10, 1);
                add(1, 0, 0, '0, '0, 0, rk[10], 4'd10, 0);
            end
        end
        add(1, 0, 1, '0, '0, 1, rk[0], 4'd0, 0);
        add(1, 0, 1, '0, PT, 1, PT ^ rk[1], 4'd1, 0);
        add(1, 0, 1, '0, '0, 1, rk[2], 4'd2, 0);
        add(1, 0, 1, '0, '0, 1, rk[3], 4'd3, 0);
        add(1, 1, 0, K2, '0, 0, rk[3], 4'd3, 0);
        add(1, 0, 1, '0, '0, 1, K2,   4'd0, 0);
        add(1, 0, 1, '0, '0, 1, K2R1, 4'd1, 0);

        // Reset held with random inputs.
        rst_n = 1'b0;
        drive(1'b1, 1'($urandom), 1'b1, {4{$urandom}}, {4{$urandom}});
        #1;
        chk_out("reset", 0, '0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'($urandom), 1'b1, {4{$urandom}}, {4{$urandom}});
            @(posedge clk); #1;
            chk_out($sformatf("reset_hold%0d", c), 0, '0, 0, 0);
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;

        foreach (vq[n]) begin
            drive(vq[n].en, vq[n].start, vq[n].valid, vq[n].key, vq[n].state);
            @(posedge clk); #1;
            chk_out($sformatf("vec%0d", n), vq[n].ev, vq[n].es, vq[n].er, vq[n].el);
        end

        // Advance the K2 sequence to round 5, then reset mid-cycle.
        for (int r = 2; r <= 4; r++) begin
            drive(1, 0, 1, '0, '0);
            @(posedge clk); #1;
        end
        drive(1, 0, 1, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, '0, 0, 0);
        @(posedge clk); #1;
        chk_out("async_rst_hold", 0, '0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_out("post_rst_blk0", 1, '0, 0, 0);
        @(posedge clk); #1;
        chk_out("post_rst_blk1", 1, ZK1, 1, 0);

        drive(1, 0, 0, '0, '0);
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
